// File: rtl/irisc_pkg.sv
// Shared definitions for the IITB-RISC core: instruction opcodes, the
// default fetch PC increment and the encoding of the fetch-unit FSM.
package irisc_pkg;

    // Byte-addressed memory holding 16-bit instructions.
    localparam int PC_STEP_DEFAULT = 2;

    // Major opcode, instruction bits [15:12].
    typedef enum logic [3:0] {
        OP_ADI  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_NAND = 4'b0010,
        OP_LLI  = 4'b0011,
        OP_LW   = 4'b0100,
        OP_SW   = 4'b0101,
        OP_LM   = 4'b0110,
        OP_SM   = 4'b0111,
        OP_BEQ  = 4'b1000,
        OP_BLT  = 4'b1001,
        OP_JAL  = 4'b1100,
        OP_JLR  = 4'b1101,
        OP_JRI  = 4'b1111
    } opcode_e;

    // Fetch-unit FSM states.
    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

endpackage : irisc_pkg

// File: rtl/irisc_fetch_fifo.sv
// Prefetch FIFO for the fetch unit: synchronous FIFO with synchronous flush
// and an occupancy count.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       empties the FIFO; overrides push and pop in the same cycle
//   push        write push_data at the tail
//   push_data   entry written on push
//   pop         drop the head entry (ignored while empty)
//   head_data   current head entry (undefined content while empty)
//   count       number of stored entries, 0..DEPTH
//   empty       count == 0
module irisc_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic             full;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;

    assign head_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only the pointers and count
    // define which entries are valid, and leaving it out of reset lets it map
    // onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // The issuer's credit scheme must never let a push land on a full FIFO
    // unless the head leaves in the same cycle.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && full && !do_pop));

endmodule : irisc_fetch_fifo

// File: rtl/irisc_fetch_unit.sv
// Instruction-fetch front end for the IITB-RISC core. Issues pipelined,
// in-order requests to instruction memory, buffers responses in a prefetch
// FIFO and hands {pc, instr} to decode over valid/ready. A redirect flushes
// the FIFO and discards responses still in flight; halt stops new issue.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_ready  request channel to instruction memory
//   imem_rvalid/imem_rdata         in-order read responses
//   instr_valid/instr_ready        handshake to decode
//   instr_data/instr_pc            head instruction and its PC (0 when empty)
//   redirect_valid/redirect_pc     single-cycle taken branch/jump
//   halt                           level; stops issuing new requests
module irisc_fetch_unit
    import irisc_pkg::*;
#(
    parameter int              DATA_W     = 16,
    parameter int              ADDR_W     = 16,
    parameter int              FIFO_DEPTH = 4,
    parameter int              PC_STEP    = PC_STEP_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  discard_q;
    logic [ADDR_W-1:0] resp_pc_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              drop_resp;
    logic              push;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is
        // inferred.
        state_d = state_q;
        case (state_q)
            FS_BOOT:   state_d = FS_RUN;
            FS_RUN:    if (halt)  state_d = FS_HALTED;
            FS_HALTED: if (!halt) state_d = FS_RUN;
            default:   state_d = FS_BOOT;
        endcase
    end

    // -------------------------------------------------------------- issue
    // Buffered plus outstanding entries may never exceed the FIFO depth, so
    // every response is guaranteed a slot.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign imem_req  = (state_q == FS_RUN) & ~halt & ~redirect_valid
                     & (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign issue     = imem_req & imem_ready;

    // ----------------------------------------------------------- response
    // Responses belonging to a squashed path are dropped: those counted in
    // discard, and any that arrive in the redirect cycle itself.
    assign drop_resp = imem_rvalid & (redirect_valid | (discard_q != '0));
    assign push      = imem_rvalid & ~drop_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr <= RESET_PC;
            resp_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            imem_addr <= redirect_pc;
            resp_pc_q <= redirect_pc;
        end else begin
            if (issue) begin
                imem_addr <= imem_addr + ADDR_W'(PC_STEP);
            end
            if (push) begin
                resp_pc_q <= resp_pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(imem_rvalid);
            // No issue happens in a redirect cycle, so this equals the
            // post-redirect inflight count: everything still out is stale.
            if (redirect_valid) begin
                discard_q <= inflight_q - CNT_W'(imem_rvalid);
            end else if (imem_rvalid && discard_q != '0) begin
                discard_q <= discard_q - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------ prefetch FIFO
    irisc_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({resp_pc_q, imem_rdata}),
        .pop       (instr_ready),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Head fields read as zero while empty so decode never sees stale data.
    assign instr_valid = ~fifo_empty;
    assign instr_pc    = instr_valid ? fifo_head[ENTRY_W-1:DATA_W] : '0;
    assign instr_data  = instr_valid ? fifo_head[DATA_W-1:0]       : '0;

endmodule : irisc_fetch_unit

// File: tb/tb_irisc_fetch_unit.sv
// Self-checking bench for irisc_fetch_unit (default parameters). A small
// memory model answers each accepted request after a programmable latency
// with data = addr + 0x1000, so every expected instruction follows from its PC.
module tb_irisc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;

    always #5 clk = ~clk;

    irisc_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        return addr + 16'h1000;
    endfunction

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [15:0] acc_addr[$];
    logic [15:0] pop_pc[$];
    logic [15:0] pop_data[$];
    int          cyc = 0;
    int          lat = 1;

    // One clock: log the transfers that the coming edge will perform, then
    // drive the memory response for the next cycle at the falling edge.
    task automatic tick();
        #1;
        if (rst_n && imem_req && imem_ready) begin
            pend.push_back('{imem_addr, cyc + lat});
            acc_addr.push_back(imem_addr);
        end
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            pop_pc.push_back(instr_pc);
            pop_data.push_back(instr_data);
        end
        @(negedge clk);
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req"},   32'(imem_req),    32'd0);
        check({tag, " addr"},  32'(imem_addr),   32'h0);
        check({tag, " valid"}, 32'(instr_valid), 32'd0);
        check({tag, " data"},  32'(instr_data),  32'h0);
        check({tag, " pc"},    32'(instr_pc),    32'h0);
    endtask

    typedef struct {
        logic        ir;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_acc;
        logic [15:0] last_acc;
        int          waited;

        // Slot-by-slot expectations from reset release, 1-cycle memory,
        // decode ready until slot 6, then one single-cycle pop at slot 10.
        vecs[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0002};
        vecs[4]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0004};
        vecs[5]  = '{1'b0, 1'b1, 16'h000A, 1'b1, 16'h0006};
        vecs[6]  = '{1'b0, 1'b1, 16'h000C, 1'b1, 16'h0006};
        vecs[7]  = '{1'b0, 1'b0, 16'h000E, 1'b1, 16'h0006};
        vecs[8]  = '{1'b0, 1'b0, 16'h000E, 1'b1, 16'h0006};
        vecs[9]  = '{1'b1, 1'b0, 16'h000E, 1'b1, 16'h0006};
        vecs[10] = '{1'b0, 1'b1, 16'h000E, 1'b1, 16'h0008};
        vecs[11] = '{1'b0, 1'b0, 16'h0010, 1'b1, 16'h0008};
        vecs[12] = '{1'b0, 1'b0, 16'h0010, 1'b1, 16'h0008};

        rst_n          = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // ---------------- streaming, credit limit, single pop
        @(negedge clk);
        rst_n       = 1'b1;
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("boot req", 32'(imem_req), 32'd0);
        tick();
        for (int i = 0; i < 13; i++) begin
            instr_ready = vecs[i].ir;
            #1;
            check($sformatf("vec%0d req", i),   32'(imem_req),    32'(vecs[i].req));
            check($sformatf("vec%0d addr", i),  32'(imem_addr),   32'(vecs[i].addr));
            check($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d pc", i),    32'(instr_pc),    32'(vecs[i].pc));
            check($sformatf("vec%0d data", i),  32'(instr_data),
                  vecs[i].valid ? 32'(vecs[i].pc + 16'h1000) : 32'h0);
            tick();
        end

        // ---------------- memory not ready: address held, no phantom issue
        pop_pc.delete();
        pop_data.delete();
        imem_ready  = 1'b0;
        instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall%0d req", i),  32'(imem_req),  32'd1);
            check($sformatf("stall%0d addr", i), 32'(imem_addr), 32'h0010);
            tick();
        end
        imem_ready = 1'b1;
        repeat (4) tick();
        check("stall pops", 32'(pop_pc.size()), 32'd6);
        for (int i = 0; i < 6 && i < pop_pc.size(); i++) begin
            check($sformatf("stall pop%0d pc", i),   32'(pop_pc[i]),   32'(16'h0008 + 16'(2 * i)));
            check($sformatf("stall pop%0d data", i), 32'(pop_data[i]), 32'(16'h1008 + 16'(2 * i)));
        end

        // ---------------- redirect with a 3-cycle memory
        lat = 3;
        repeat (8) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        #1;
        check("redir cycle req", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        pop_pc.delete();
        pop_data.delete();
        #1;
        check("redir valid", 32'(instr_valid), 32'd0);
        check("redir addr",  32'(imem_addr),   32'h0040);
        check("redir req",   32'(imem_req),    32'd1);
        waited = 0;
        while (pop_pc.size() < 3 && waited < 30) begin
            tick();
            waited++;
        end
        check("redir pops", 32'(pop_pc.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < pop_pc.size(); i++) begin
            check($sformatf("redir pop%0d pc", i),   32'(pop_pc[i]),   32'(16'h0040 + 16'(2 * i)));
            check($sformatf("redir pop%0d data", i), 32'(pop_data[i]), 32'(16'h1040 + 16'(2 * i)));
        end

        // ---------------- halt mid-stream
        lat = 1;
        repeat (6) tick();
        halt = 1'b1;
        #1;
        check("halt req", 32'(imem_req), 32'd0);
        n_acc    = acc_addr.size();
        last_acc = acc_addr[$];
        pop_pc.delete();
        pop_data.delete();
        repeat (6) tick();
        #1;
        check("halt req held", 32'(imem_req), 32'd0);
        check("halt no issue", 32'(acc_addr.size()), 32'(n_acc));
        check("halt drained",  32'(pop_pc.size() > 0), 32'd1);
        if (pop_pc.size() > 0) begin
            check("halt last pc",   32'(pop_pc[$]),   32'(last_acc));
            check("halt last data", 32'(pop_data[$]), 32'(last_acc + 16'h1000));
        end
        halt = 1'b0;
        #1;
        check("unhalt req", 32'(imem_req), 32'd0);
        tick();
        #1;
        check("resume req",  32'(imem_req),  32'd1);
        check("resume addr", 32'(imem_addr), 32'(last_acc + 16'h0002));

        // ---------------- async reset with the FIFO full
        instr_ready = 1'b0;
        repeat (10) tick();
        #1;
        check("full valid", 32'(instr_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async rst");
        pend.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        @(negedge clk);
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        pop_pc.delete();
        pop_data.delete();
        #1;
        check("reboot req", 32'(imem_req), 32'd0);
        tick();
        #1;
        check("reboot req1",  32'(imem_req),  32'd1);
        check("reboot addr1", 32'(imem_addr), 32'h0000);
        repeat (8) tick();
        check("reboot pops", 32'(pop_pc.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
            check($sformatf("reboot pop%0d pc", i),   32'(pop_pc[i]),   32'(16'(2 * i)));
            check($sformatf("reboot pop%0d data", i), 32'(pop_data[i]), 32'(16'h1000 + 16'(2 * i)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_irisc_fetch_unit
